// File: rtl/encaps_rq_engine.sv
// encaps_rq_engine
//   Serial encapsulation engine. The engine samples ternary r and m from a coin
//   stream. It then computes c = r*h + lift(m) in Z_q[x]/(x^N-1), where q = 2^LOGQ.
//   c is streamed out one coefficient at a time, in index order.
//
// Parameters: N (coefficients, >=2), LOGQ (coef width, q = 2^LOGQ), CW (coin width)
// Ports:
//   clk                   clock, posedge
//   rst                   synchronous active-low reset
//   start                 begin one encapsulation (honoured only when idle)
//   busy, done            status; done pulses once after the last c handshake
//   coin/coin_valid/coin_ready       coin stream; a coin maps to a ternary value (coin mod 3)
//   h                     public key, coef k at [k*LOGQ +: LOGQ], stable while busy
//   c_coef/c_idx/c_valid/c_ready     result stream
// Build option: define LIFT_PHI1_EN to lift m as m*(x-1); otherwise lift(m) = m.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// SAMPLE_R | taking N coins into r[]
// SAMPLE_M | taking N coins into m[]
// MAC      | 1 cycle loading lift(m)[i], then N cycles accumulating r[j]*h[i-j]
// OUT      | presenting c[i] until c_ready
// DONE     | one-cycle done pulse
module encaps_rq_engine #(
    parameter int N    = 701,
    parameter int LOGQ = 13,
    parameter int CW   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    input  logic [CW-1:0]           coin,
    input  logic                    coin_valid,
    output logic                    coin_ready,
    input  logic [N*LOGQ-1:0]       h,
    output logic [LOGQ-1:0]         c_coef,
    output logic [$clog2(N)-1:0]    c_idx,
    output logic                    c_valid,
    input  logic                    c_ready
);
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE_R, S_SAMPLE_M, S_MAC, S_OUT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d, i_q, i_d, j_q, j_d, k_q, k_d;
    logic              first_q, first_d;
    logic [LOGQ-1:0]   acc_q, acc_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              coin_ready_q, coin_ready_d, c_valid_q, c_valid_d;
    logic [LOGQ-1:0]   c_coef_q, c_coef_d;
    logic [IW-1:0]     c_idx_q, c_idx_d;

    // Ternary codes: 0 -> 0, 1 -> +1, 2 -> -1
    logic [1:0]        r_q [N];
    logic [1:0]        m_q [N];
    logic              r_we, m_we;
    logic [1:0]        coin_t;
    logic [LOGQ-1:0]   lift_val, h_coef, term;

    function automatic logic [LOGQ-1:0] tern_val(input logic [1:0] t);
        case (t)
            2'd1:    return LOGQ'(1);
            2'd2:    return '1;
            default: return '0;
        endcase
    endfunction

`ifdef LIFT_PHI1_EN
    logic [IW-1:0] i_prev;
    assign i_prev   = (i_q == '0) ? IW'(N-1) : i_q - 1'b1;
    assign lift_val = tern_val(m_q[i_prev]) - tern_val(m_q[i_q]);
`else
    assign lift_val = tern_val(m_q[i_q]);
`endif

    // k_q tracks (i-j) mod N as a wrapping down-counter.
    assign h_coef = h[int'(k_q)*LOGQ +: LOGQ];

    always_comb begin
        case (r_q[j_q])
            2'd1:    term = h_coef;
            2'd2:    term = '0 - h_coef;
            default: term = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        first_d = first_q;
        acc_d   = acc_q;
        r_we    = 1'b0;
        m_we    = 1'b0;
        coin_t  = 2'(coin % CW'(3));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SAMPLE_R;
                    cnt_d   = '0;
                end
            end
            S_SAMPLE_R, S_SAMPLE_M: begin
                if (coin_valid && coin_ready_q) begin
                    r_we = (state_q == S_SAMPLE_R);
                    m_we = (state_q == S_SAMPLE_M);
                    if (cnt_q == IW'(N-1)) begin
                        cnt_d = '0;
                        if (state_q == S_SAMPLE_R) begin
                            state_d = S_SAMPLE_M;
                        end else begin
                            state_d = S_MAC;
                            i_d     = '0;
                            j_d     = '0;
                            k_d     = '0;
                            first_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                if (first_q) begin
                    acc_d   = lift_val;
                    first_d = 1'b0;
                end else begin
                    acc_d = acc_q + term;
                    j_d   = j_q + 1'b1;
                    k_d   = (k_q == '0) ? IW'(N-1) : k_q - 1'b1;
                    if (j_q == IW'(N-1)) begin
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (c_ready) begin
                    if (i_q == IW'(N-1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MAC;
                        i_d     = i_q + 1'b1;
                        j_d     = '0;
                        k_d     = i_q + 1'b1;
                        first_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        busy_d       = (state_d inside {S_SAMPLE_R, S_SAMPLE_M, S_MAC, S_OUT});
        coin_ready_d = (state_d inside {S_SAMPLE_R, S_SAMPLE_M});
        c_valid_d    = (state_d == S_OUT);
        done_d       = (state_d == S_DONE);
        c_coef_d     = (state_d == S_OUT) ? acc_d : c_coef_q;
        c_idx_d      = (state_d == S_OUT) ? i_d   : c_idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            i_q          <= '0;
            j_q          <= '0;
            k_q          <= '0;
            first_q      <= 1'b0;
            acc_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            coin_ready_q <= 1'b0;
            c_valid_q    <= 1'b0;
            c_coef_q     <= '0;
            c_idx_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            i_q          <= i_d;
            j_q          <= j_d;
            k_q          <= k_d;
            first_q      <= first_d;
            acc_q        <= acc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            coin_ready_q <= coin_ready_d;
            c_valid_q    <= c_valid_d;
            c_coef_q     <= c_coef_d;
            c_idx_q      <= c_idx_d;
            // r/m storage is deliberately left out of reset.
            if (r_we) r_q[cnt_q] <= coin_t;
            if (m_we) m_q[cnt_q] <= coin_t;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign coin_ready = coin_ready_q;
    assign c_valid    = c_valid_q;
    assign c_coef     = c_coef_q;
    assign c_idx      = c_idx_q;

endmodule

// File: tb/tb_encaps_rq_engine.sv
module tb_encaps_rq_engine;
    localparam int N = 5, LOGQ = 4, CW = 8, IW = 3;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, coin_valid = 1'b0, c_ready = 1'b0;
    logic [CW-1:0]      coin = '0;
    logic [N*LOGQ-1:0]  h;
    logic               busy, done, coin_ready, c_valid;
    logic [LOGQ-1:0]    c_coef;
    logic [IW-1:0]      c_idx;

    encaps_rq_engine #(.N(N), .LOGQ(LOGQ), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .coin(coin), .coin_valid(coin_valid), .coin_ready(coin_ready), .h(h),
        .c_coef(c_coef), .c_idx(c_idx), .c_valid(c_valid), .c_ready(c_ready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    typedef struct { int idx; int coef; } exp_t;
    exp_t sb[$];
    int hv[N] = '{3, 5, 7, 9, 11};
    int rc[N], mc[N];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int tern(input int c);
        case (c % 3)
            0:       return 0;
            1:       return 1;
            default: return -1;
        endcase
    endfunction

    // Reference: plain cyclic convolution plus lift, reduced mod 16.
    function automatic void model();
        for (int i = 0; i < N; i++) begin
            int acc;
`ifdef LIFT_PHI1_EN
            acc = tern(mc[(i + N - 1) % N]) - tern(mc[i]);
`else
            acc = tern(mc[i]);
`endif
            for (int j = 0; j < N; j++)
                acc += tern(rc[j]) * hv[(i - j + N) % N];
            sb.push_back('{i, ((acc % 16) + 16) % 16});
        end
    endfunction

    always @(negedge clk) begin
        if (rst && c_valid && c_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_c actual_idx=%0d required=no_output", c_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("c_idx", int'(c_idx), e.idx);
                check("c_coef", int'(c_coef), e.coef);
            end
        end
    end

    task automatic feed_coin(input int val, input bit gaps);
        int b;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                coin_valid = 1'b0;
                coin = CW'($urandom);
                @(posedge clk); #1;
            end
        end
        coin = CW'(val);
        coin_valid = 1'b1;
        b = 0;
        forever begin
            @(negedge clk);
            if (coin_ready) begin
                @(posedge clk); #1;
                break;
            end
            b++;
            if (b > 50) begin
                check("coin_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic run(input bit do_start, input bit gaps, input bit rand_ready,
                       input bit stall2, input bit start_mid);
        int cyc, dones;
        bit pv, pr, stalled, finished;
        int pi;
        model();
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check("busy_after_start", int'(busy), 1);
        end
        for (int i = 0; i < N; i++) feed_coin(rc[i], gaps);
        for (int i = 0; i < N; i++) feed_coin(mc[i], gaps);
        coin_valid = 1'b1;            // junk coins outside sampling must be ignored
        coin = CW'($urandom);
        c_ready = 1'b1;
        cyc = 0; dones = 0; stalled = 1'b0; finished = 1'b0;
        while (cyc < 3000) begin
            pv = c_valid; pr = c_ready; pi = int'(c_idx);
            @(posedge clk); #1;
            cyc++;
            if (done) dones++;
            if (pv && pr && pi == N - 1) begin
                check("done_after_last", int'(done), 1);
                finished = 1'b1;
                break;
            end
            if (cyc == 3) begin
                check("coin_ready_in_mac", int'(coin_ready), 0);
                check("busy_in_mac", int'(busy), 1);
            end
            start = (start_mid && cyc == 8);
            if (stall2 && !stalled && c_valid && c_idx == 3'd2) begin
                logic [LOGQ-1:0] sc;
                stalled = 1'b1;
                c_ready = 1'b0;
                sc = c_coef;
                repeat (10) begin
                    @(posedge clk); #1;
                    cyc++;
                    check("stall_valid", int'(c_valid), 1);
                    check("stall_coef", int'(c_coef), int'(sc));
                    check("stall_idx", int'(c_idx), 2);
                end
                c_ready = 1'b1;
            end else if (rand_ready) begin
                c_ready = ($urandom_range(0, 3) != 0);
            end
        end
        start = 1'b0;
        if (!finished) check("run_timeout", 0, 1);
        check("done_count", dones, 1);
        check("sb_drained", sb.size(), 0);
        sb.delete();
        @(posedge clk); #1;
        check("done_low_after", int'(done), 0);
        check("busy_after_done", int'(busy), 0);
        coin_valid = 1'b0;
    endtask

    task automatic set_coins(input int r0, r1, r2, r3, r4, m0, m1, m2, m3, m4);
        rc = '{r0, r1, r2, r3, r4};
        mc = '{m0, m1, m2, m3, m4};
    endtask

    task automatic rand_coins();
        for (int i = 0; i < N; i++) begin
            rc[i] = $urandom_range(0, 255);
            mc[i] = $urandom_range(0, 255);
        end
    endtask

    initial begin
        int dseen;
        for (int k = 0; k < N; k++) h[k*LOGQ +: LOGQ] = LOGQ'(hv[k]);

        // Reset holds everything low even with start asserted
        rst = 1'b0;
        start = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_coin_ready", int'(coin_ready), 0);
            check("rst_c_valid", int'(c_valid), 0);
            check("rst_c_coef", int'(c_coef), 0);
            check("rst_c_idx", int'(c_idx), 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("busy_after_release", int'(busy), 1);
        start = 1'b0;

        set_coins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_coins(255, 255, 255, 255, 255, 255, 255, 255, 255, 255);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_coins(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_coins(0, 254, 0, 0, 0, 0, 0, 0, 0, 0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        set_coins(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Gaps, stall at idx 2, and a stray start mid-run
        rand_coins();
        run(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

        // Abort during MAC: no output, no done
        rand_coins();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < N; i++) feed_coin(rc[i], 1'b0);
        for (int i = 0; i < N; i++) feed_coin(mc[i], 1'b0);
        coin_valid = 1'b0;
        c_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_c_valid", int'(c_valid), 0);
        check("abort_coin_ready", int'(coin_ready), 0);
        dseen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done || c_valid || busy) dseen++;
        end
        check("abort_quiet", dseen, 0);

        // Fresh runs after abort
        rand_coins();
        run(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) begin
            rand_coins();
            run(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
